// File: rtl/inst_fetch_if.sv
// Signal bundle between the fetch stage, the instruction ROM and the decode stage.
// master = the fetch stage, slave = ROM/decode side.
interface inst_fetch_if;
  logic [31:0] pc_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        halt;
  logic        br_taken;
  logic        jump;
  logic [31:0] id_pc4;
  logic [15:0] br_imm;
  logic [25:0] jmp_idx;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_cnt;
  logic        halted;

  modport master (
    output pc_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid, fetch_cnt, halted,
    input  rom_inst, stall, halt, br_taken, jump, id_pc4, br_imm, jmp_idx
  );

  modport slave (
    input  pc_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid, fetch_cnt, halted,
    output rom_inst, stall, halt, br_taken, jump, id_pc4, br_imm, jmp_idx
  );
endinterface

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC register, IF/ID capture register, redirect
// handling from decode and a count of valid instructions fetched.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] ipc_reg, ipc_next;
  logic [31:0] ipc4_reg, ipc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] cnt_reg, cnt_next;

  logic [31:0] jmp_target;
  logic [31:0] br_target;
  logic [31:0] redir_target;
  logic        redir;

  assign jmp_target   = {bus.id_pc4[31:28], bus.jmp_idx, 2'b00};
  assign br_target    = bus.id_pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  // jump wins over a simultaneous taken branch
  assign redir        = bus.jump | bus.br_taken;
  assign redir_target = bus.jump ? jmp_target : br_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      inst_reg  <= NOP_INST;
      ipc_reg   <= 32'h0;
      ipc4_reg  <= 32'h0;
      valid_reg <= 1'b0;
      cnt_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      ipc_reg   <= ipc_next;
      ipc4_reg  <= ipc4_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    ipc_next   = ipc_reg;
    ipc4_next  = ipc4_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      BOOT: begin
        inst_next  = NOP_INST;
        valid_next = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        if (bus.stall) begin
          // decode is frozen, so any redirect it shows now is not yet final
        end else if (bus.halt) begin
          if (redir) pc_next = redir_target;
          inst_next  = NOP_INST;
          valid_next = 1'b0;
          state_next = HALT;
        end else if (redir) begin
          // the word fetched this cycle is on the wrong path: squash it
          pc_next    = redir_target;
          inst_next  = NOP_INST;
          valid_next = 1'b0;
        end else begin
          inst_next  = bus.rom_inst;
          ipc_next   = pc_reg;
          ipc4_next  = pc_reg + 32'd4;
          valid_next = 1'b1;
          pc_next    = pc_reg + 32'd4;
          cnt_next   = cnt_reg + 32'd1;
        end
      end
      HALT: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign bus.pc_addr     = pc_reg;
  assign bus.if_id_inst  = inst_reg;
  assign bus.if_id_pc    = ipc_reg;
  assign bus.if_id_pc4   = ipc4_reg;
  assign bus.if_id_valid = valid_reg;
  assign bus.fetch_cnt   = cnt_reg;
  assign bus.halted      = (state_reg == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized redirects/stalls/resets,
// checked every cycle against a rule-level model of the fetch stage.
module tb_inst_fetch;

  logic clk;
  logic rst_n;
  bit   chk_on;
  int   n_assert;
  int   n_fail;

  inst_fetch_if ifc();

  inst_fetch #(.RESET_PC(32'h00000000), .NOP_INST(32'h00000000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h00: rom_fn = 32'h20080005;
      32'h04: rom_fn = 32'h2009000A;
      32'h08: rom_fn = 32'h01095020;
      32'h0C: rom_fn = 32'h11090002;
      32'h10: rom_fn = 32'hAC0A0000;
      32'h14: rom_fn = 32'h8C0B0000;
      32'h18: rom_fn = 32'h08000000;
      32'h1C: rom_fn = 32'h014B6022;
      default: rom_fn = a ^ 32'h5A5AA5A5 ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  assign ifc.rom_inst = rom_fn(ifc.pc_addr);

  // Reference model: what each output must be, derived from the fetch rules
  bit          m_boot, m_halt, m_valid;
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_halt <= 1'b0; m_valid <= 1'b0;
      m_pc <= 32'h0; m_inst <= 32'h0; m_ipc <= 32'h0; m_ipc4 <= 32'h0; m_cnt <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_inst <= 32'h0; m_valid <= 1'b0;
    end else if (!m_halt && !ifc.stall) begin
      if (ifc.halt || ifc.jump || ifc.br_taken) begin
        m_inst  <= 32'h0;
        m_valid <= 1'b0;
        m_halt  <= ifc.halt;
        if (ifc.jump)
          m_pc <= (ifc.id_pc4 & 32'hF0000000) + 32'(ifc.jmp_idx) * 32'd4;
        else if (ifc.br_taken)
          m_pc <= ifc.id_pc4 + 32'($signed(ifc.br_imm)) * 32'd4;
      end else begin
        m_inst  <= rom_fn(m_pc);
        m_ipc   <= m_pc;
        m_ipc4  <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 32'd4;
        m_cnt   <= m_cnt + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc_addr",     ifc.pc_addr,            m_pc);
      chk("if_id_inst",  ifc.if_id_inst,         m_inst);
      chk("if_id_pc",    ifc.if_id_pc,           m_ipc);
      chk("if_id_pc4",   ifc.if_id_pc4,          m_ipc4);
      chk("if_id_valid", 32'(ifc.if_id_valid),   32'(m_valid));
      chk("fetch_cnt",   ifc.fetch_cnt,          m_cnt);
      chk("halted",      32'(ifc.halted),        32'(m_halt));
      chk("pc_align",    32'(ifc.pc_addr[1:0]),  32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.stall = 1'b0; ifc.halt = 1'b0; ifc.br_taken = 1'b0; ifc.jump = 1'b0;
    ifc.id_pc4 = 32'h0; ifc.br_imm = 16'h0; ifc.jmp_idx = 26'h0;
  endtask

  task automatic randin();
    ifc.stall    = ($urandom_range(0, 4) == 0);
    ifc.halt     = ($urandom_range(0, 255) == 0);
    ifc.jump     = ($urandom_range(0, 7) == 0);
    ifc.br_taken = ($urandom_range(0, 5) == 0);
    ifc.id_pc4   = $urandom_range(0, 1) ? ($urandom & 32'h000000FC) : ($urandom & 32'hFFFFFFFC);
    ifc.br_imm   = 16'($urandom);
    ifc.jmp_idx  = $urandom_range(0, 1) ? 26'($urandom_range(0, 15)) : 26'($urandom);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    chk_on   = 1'b0;
    rst_n    = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    chk_on = 1'b1;

    // reset held with random inputs
    repeat (3) begin randin(); tick(); end
    chk("rst_pc",    ifc.pc_addr,          32'h0);
    chk("rst_valid", 32'(ifc.if_id_valid), 32'h0);
    chk("rst_cnt",   ifc.fetch_cnt,        32'h0);
    chk("rst_halt",  32'(ifc.halted),      32'h0);

    // BOOT ignores a redirect
    rst_n = 1'b1;
    idle();
    ifc.jump = 1'b1; ifc.id_pc4 = 32'h40000000; ifc.jmp_idx = 26'h123;
    tick();
    chk("boot_pc",    ifc.pc_addr,          32'h0);
    chk("boot_valid", 32'(ifc.if_id_valid), 32'h0);

    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_pc",    ifc.if_id_pc,         32'(4 * k));
      chk("seq_inst",  ifc.if_id_inst,       rom_fn(32'(4 * k)));
      chk("seq_valid", 32'(ifc.if_id_valid), 32'h1);
    end
    chk("seq_pcaddr", ifc.pc_addr, 32'h0C);

    // stall with a branch pulse that must be ignored
    for (int k = 0; k < 3; k++) begin
      ifc.stall = 1'b1; ifc.br_taken = (k == 1); ifc.id_pc4 = 32'h100;
      tick();
      chk("stall_pc",  ifc.pc_addr,   32'h0C);
      chk("stall_cnt", ifc.fetch_cnt, 32'd3);
      chk("stall_ifpc", ifc.if_id_pc, 32'h08);
    end
    idle();
    tick();
    chk("unstall_pc", ifc.if_id_pc, 32'h0C);
    tick(); tick();
    chk("seq6_pc",  ifc.if_id_pc,  32'h14);
    chk("seq6_pc4", ifc.if_id_pc4, 32'h18);
    chk("seq6_cnt", ifc.fetch_cnt, 32'd6);

    // backward branch
    ifc.br_taken = 1'b1; ifc.id_pc4 = 32'h14; ifc.br_imm = 16'hFFFC;
    tick();
    chk("br_pc",    ifc.pc_addr,          32'h04);
    chk("br_valid", 32'(ifc.if_id_valid), 32'h0);
    idle();
    tick();
    chk("br_tgt",   ifc.if_id_pc,         32'h04);
    chk("br_tgt_v", 32'(ifc.if_id_valid), 32'h1);

    ifc.jump = 1'b1; ifc.id_pc4 = 32'h20; ifc.jmp_idx = 26'h4;
    tick();
    chk("j_pc", ifc.pc_addr, 32'h10);
    idle();
    tick();
    chk("j_tgt", ifc.if_id_pc, 32'h10);

    // jump and branch together
    ifc.jump = 1'b1; ifc.br_taken = 1'b1; ifc.id_pc4 = 32'h20; ifc.jmp_idx = 26'h8; ifc.br_imm = 16'h0001;
    tick();
    chk("jb_pc", ifc.pc_addr, 32'h20);

    // PC wrap
    idle();
    ifc.jump = 1'b1; ifc.id_pc4 = 32'hF0000000; ifc.jmp_idx = 26'h3FFFFFF;
    tick();
    chk("wrap_top", ifc.pc_addr, 32'hFFFFFFFC);
    idle();
    tick();
    chk("wrap_pc",   ifc.pc_addr,   32'h0);
    chk("wrap_ifpc", ifc.if_id_pc,  32'hFFFFFFFC);
    chk("wrap_pc4",  ifc.if_id_pc4, 32'h0);

    // halt together with a jump
    ifc.halt = 1'b1; ifc.jump = 1'b1; ifc.id_pc4 = 32'h20; ifc.jmp_idx = 26'h5;
    tick();
    chk("hj_pc",    ifc.pc_addr,     32'h14);
    chk("hj_halted", 32'(ifc.halted), 32'h1);
    for (int k = 0; k < 12; k++) begin
      randin();
      tick();
      chk("halt_hold_pc", ifc.pc_addr,          32'h14);
      chk("halt_valid",   32'(ifc.if_id_valid), 32'h0);
      chk("halt_halted",  32'(ifc.halted),      32'h1);
    end

    // async reset inside HALT, between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_h_pc",     ifc.pc_addr,     32'h0);
    chk("arst_h_halted", 32'(ifc.halted), 32'h0);
    chk("arst_h_cnt",    ifc.fetch_cnt,   32'h0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    chk("arst_h_boot", 32'(ifc.if_id_valid), 32'h0);
    tick();
    chk("arst_h_first",  ifc.if_id_pc,   32'h0);
    chk("arst_h_inst",   ifc.if_id_inst, rom_fn(32'h0));

    // async reset during a stall
    ifc.stall = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_pc",  ifc.pc_addr,   32'h0);
    chk("arst_s_cnt", ifc.fetch_cnt, 32'h0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    chk("arst_s_boot", 32'(ifc.if_id_valid), 32'h0);

    // randomized traffic with occasional mid-cycle reset pulses
    for (int k = 0; k < 3000; k++) begin
      randin();
      tick();
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
